// File: rtl/lcd_fb_writer.sv
// lcd_fb_writer: captures the WonderSwan Color LCD pixel bus and writes each
// pixel into the 36-bit packed framebuffer RAM (three 12-bit lanes per word).
// The whole block runs in the framebuffer write clock domain; all LCD inputs
// are oversampled through a flop synchronizer and edge-detected here.
//
// Handshake/timing contract: there is no backpressure. Each accepted pixel
// produces exactly one single-cycle wrEn pulse, SYNCSTAGES+2 clk cycles after
// the lcdClk rising edge, with wrAddr/wrData/wrLaneEn valid in that same cycle.
// frameDone pulses one cycle after the last write of the frame.
module lcd_fb_writer #(
  parameter int COLLEN     = 75,
  parameter int LINEPIXELS = 224,
  parameter int LINES      = 144,
  parameter int SYNCSTAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcdClk,
  input  logic        lcdHsync,
  input  logic        lcdVsync,
  input  logic [11:0] lcdData,
  output logic        wrEn,
  output logic [13:0] wrAddr,
  output logic [35:0] wrData,
  output logic [2:0]  wrLaneEn,
  output logic        frameDone,
  output logic [7:0]  lineCnt,
  output logic        syncErr
);

  localparam int COL_W = (COLLEN > 1) ? $clog2(COLLEN) : 1;
  localparam int PX_W  = $clog2(LINEPIXELS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HS = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Bit 0 is the first stage, bit SYNCSTAGES-1 the last.
  // Data travels through the same number of stages as lcdClk so that the
  // sampled pixel is aligned with the detected clock edge.
  // ---------------------------------------------------------------------------
  logic [SYNCSTAGES-1:0] clk_sync;
  logic [SYNCSTAGES-1:0] hs_sync;
  logic [SYNCSTAGES-1:0] vs_sync;
  logic [11:0]           data_sync [SYNCSTAGES];
  logic                  clk_dly;
  logic                  hs_dly;
  logic                  vs_dly;

  // Shift asynchronous LCD inputs through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync <= '0;
      hs_sync  <= '0;
      vs_sync  <= '0;
      for (int i = 0; i < SYNCSTAGES; i++) begin
        data_sync[i] <= '0;
      end
    end else begin
      clk_sync     <= {clk_sync[SYNCSTAGES-2:0], lcdClk};
      hs_sync      <= {hs_sync[SYNCSTAGES-2:0], lcdHsync};
      vs_sync      <= {vs_sync[SYNCSTAGES-2:0], lcdVsync};
      data_sync[0] <= lcdData;
      for (int i = 1; i < SYNCSTAGES; i++) begin
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  // Keep one extra delayed copy of each control signal for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_dly <= 1'b0;
      hs_dly  <= 1'b0;
      vs_dly  <= 1'b0;
    end else begin
      clk_dly <= clk_sync[SYNCSTAGES-1];
      hs_dly  <= hs_sync[SYNCSTAGES-1];
      vs_dly  <= vs_sync[SYNCSTAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Registered rising-edge events plus the pixel captured with the clock edge.
  // ---------------------------------------------------------------------------
  logic        ev_px;
  logic        ev_hs;
  logic        ev_vs;
  logic [11:0] ev_data;

  // Register rising edges of the synchronized signals and the aligned pixel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ev_px   <= 1'b0;
      ev_hs   <= 1'b0;
      ev_vs   <= 1'b0;
      ev_data <= '0;
    end else begin
      ev_px   <= clk_sync[SYNCSTAGES-1] & ~clk_dly;
      ev_hs   <= hs_sync[SYNCSTAGES-1] & ~hs_dly;
      ev_vs   <= vs_sync[SYNCSTAGES-1] & ~vs_dly;
      ev_data <= data_sync[SYNCSTAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM and counters.
  // ---------------------------------------------------------------------------
  state_t             state, state_n;
  logic [COL_W-1:0]   col, col_n;
  logic [1:0]         lane, lane_n;
  logic [PX_W-1:0]    px, px_n;
  logic [7:0]         line_cnt, line_n;
  logic [13:0]        line_base, base_n;
  logic               sync_err, err_n;
  logic               done_pend, done_n;
  logic               capture;
  logic               wr_en_n;
  logic [13:0]        wr_addr_n;
  logic [35:0]        wr_data_n;
  logic [2:0]         wr_lane_n;
  logic               wr_en_q;
  logic [13:0]        wr_addr_q;
  logic [35:0]        wr_data_q;
  logic [2:0]         wr_lane_q;
  logic               frame_done_q;

  // State, counters and registered write port outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      col          <= '0;
      lane         <= '0;
      px           <= '0;
      line_cnt     <= '0;
      line_base    <= '0;
      sync_err     <= 1'b0;
      done_pend    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_lane_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      col          <= col_n;
      lane         <= lane_n;
      px           <= px_n;
      line_cnt     <= line_n;
      line_base    <= base_n;
      sync_err     <= err_n;
      done_pend    <= done_n;
      wr_en_q      <= wr_en_n;
      wr_addr_q    <= wr_addr_n;
      wr_data_q    <= wr_data_n;
      wr_lane_q    <= wr_lane_n;
      frame_done_q <= done_pend;
    end
  end

  // Next-state logic: sync handling first, then the pixel capture on top of
  // whatever line position the sync handling left behind.
  always_comb begin
    state_n   = state;
    col_n     = col;
    lane_n    = lane;
    px_n      = px;
    line_n    = line_cnt;
    base_n    = line_base;
    err_n     = sync_err;
    done_n    = 1'b0;
    capture   = 1'b0;
    wr_en_n   = 1'b0;
    wr_addr_n = '0;
    wr_data_n = '0;
    wr_lane_n = '0;

    case (state)
      IDLE: begin
        if (ev_vs) begin
          state_n = WAIT_HS;
          line_n  = '0;
          base_n  = '0;
          col_n   = '0;
          lane_n  = '0;
          px_n    = '0;
        end
      end

      WAIT_HS: begin
        if (ev_vs) begin
          // A vsync anywhere but the very start of a frame is a sync error.
          if (line_cnt != 8'd0 || px != '0) err_n = 1'b1;
          line_n = '0;
          base_n = '0;
          col_n  = '0;
          lane_n = '0;
          px_n   = '0;
        end else if (ev_hs) begin
          state_n = ACTIVE;
          col_n   = '0;
          lane_n  = '0;
          px_n    = '0;
          capture = ev_px;
        end
      end

      ACTIVE: begin
        if (ev_vs) begin
          if (line_cnt != 8'd0 || px != '0) err_n = 1'b1;
          state_n = WAIT_HS;
          line_n  = '0;
          base_n  = '0;
          col_n   = '0;
          lane_n  = '0;
          px_n    = '0;
        end else if (ev_hs) begin
          // Line cut short: advance as if complete, hsync starts the next line.
          err_n = 1'b1;
          if (line_cnt == 8'(LINES - 1)) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            line_n  = line_cnt + 8'd1;
            base_n  = line_base + 14'(COLLEN);
            col_n   = '0;
            lane_n  = '0;
            px_n    = '0;
            capture = ev_px;
          end
        end else begin
          capture = ev_px;
        end
      end

      default: state_n = IDLE;
    endcase

    if (capture) begin
      wr_en_n   = 1'b1;
      wr_addr_n = base_n + 14'(col_n);
      wr_data_n = {3{ev_data}};
      wr_lane_n = 3'b100 >> lane_n;
      if (px_n == PX_W'(LINEPIXELS - 1)) begin
        // Last active pixel of the line: finish the line or the frame.
        px_n = PX_W'(LINEPIXELS);
        if (line_n == 8'(LINES - 1)) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          line_n  = line_n + 8'd1;
          base_n  = base_n + 14'(COLLEN);
          state_n = WAIT_HS;
        end
      end else begin
        px_n    = px_n + PX_W'(1);
        state_n = ACTIVE;
        if (col_n == COL_W'(COLLEN - 1)) begin
          col_n  = '0;
          lane_n = lane_n + 2'd1;
        end else begin
          col_n = col_n + COL_W'(1);
        end
      end
    end
  end

  assign wrEn      = wr_en_q;
  assign wrAddr    = wr_addr_q;
  assign wrData    = wr_data_q;
  assign wrLaneEn  = wr_lane_q;
  assign frameDone = frame_done_q;
  assign lineCnt   = line_cnt;
  assign syncErr   = sync_err;

endmodule
